// File: rtl/digit_source_arbiter_if.sv
// Digit-source bus: NCH packed producer words in, one selected display word out.
interface digit_source_arbiter_if #(
    parameter int NCH     = 2,
    parameter int DIGIT_W = 5
);
    localparam int CH_W = $clog2(NCH);

    logic [NCH*DIGIT_W-1:0] ch_data;
    logic [NCH-1:0]         ch_valid;
    logic [1:0]             mode;
    logic [CH_W-1:0]        sel;
    logic [DIGIT_W-1:0]     digit_holder;
    logic [CH_W-1:0]        active_ch;
    logic                   updated;

    modport master (
        output ch_data, ch_valid, mode, sel,
        input  digit_holder, active_ch, updated
    );

    modport slave (
        input  ch_data, ch_valid, mode, sel,
        output digit_holder, active_ch, updated
    );
endinterface

// File: rtl/digit_source_arbiter.sv
// Selects one of NCH digit producers for the 7-segment driver.
// Modes: manual, last-event, auto-rotate, freeze.
module digit_source_arbiter #(
    parameter int NCH     = 2,
    parameter int DIGIT_W = 5,
    parameter int DWELL   = 100000000
) (
    input  logic                  CLK100MHZ,
    input  logic                  CPU_RESET,
    digit_source_arbiter_if.slave bus
);
    localparam int CH_W  = $clog2(NCH);
    localparam int CNT_W = $clog2(DWELL);

    typedef enum logic [1:0] {
        MODE_MANUAL = 2'b00,
        MODE_LAST   = 2'b01,
        MODE_ROTATE = 2'b10,
        MODE_FREEZE = 2'b11
    } mode_e;

    mode_e              mode;
    logic [DIGIT_W-1:0] ch_word [NCH];
    logic [DIGIT_W-1:0] shadow  [NCH];
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [CH_W-1:0]    nxt;
    logic [DIGIT_W-1:0] nxt_digit;
    logic [DIGIT_W-1:0] digit_holder;
    logic [CH_W-1:0]    active_ch;
    logic               updated;
    logic               dwell_end;

    assign mode = mode_e'(bus.mode);

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        assign ch_word[g] = bus.ch_data[g*DIGIT_W +: DIGIT_W];

        // Shadows keep capturing in every mode, freeze included.
        always_ff @(posedge CLK100MHZ) begin
            if (CPU_RESET)
                shadow[g] <= '0;
            else if (bus.ch_valid[g])
                shadow[g] <= ch_word[g];
        end
    end

    assign dwell_end = (cnt == CNT_W'(DWELL - 1));

    always_comb begin
        nxt     = active_ch;
        cnt_nxt = '0;
        case (mode)
            MODE_MANUAL: begin
                if (int'(bus.sel) < NCH)
                    nxt = bus.sel;
            end
            MODE_LAST: begin
                // Descending scan so the lowest strobing index is written last.
                for (int i = NCH - 1; i >= 0; i--)
                    if (bus.ch_valid[i])
                        nxt = CH_W'(i);
            end
            MODE_ROTATE: begin
                cnt_nxt = dwell_end ? '0 : cnt + 1'b1;
                if (dwell_end)
                    nxt = (active_ch == CH_W'(NCH - 1)) ? '0 : active_ch + 1'b1;
            end
            default: nxt = active_ch;
        endcase
        nxt_digit = bus.ch_valid[nxt] ? ch_word[nxt] : shadow[nxt];
    end

    always_ff @(posedge CLK100MHZ) begin
        if (CPU_RESET) begin
            cnt          <= '0;
            active_ch    <= '0;
            digit_holder <= '0;
            updated      <= 1'b0;
        end else begin
            cnt <= cnt_nxt;
            if (mode != MODE_FREEZE) begin
                active_ch    <= nxt;
                digit_holder <= nxt_digit;
                updated      <= (nxt_digit != digit_holder) || (nxt != active_ch);
            end else begin
                updated      <= 1'b0;
            end
        end
    end

    assign bus.digit_holder = digit_holder;
    assign bus.active_ch    = active_ch;
    assign bus.updated      = updated;
endmodule

// File: tb/tb_digit_source_arbiter.sv
// Randomised and directed checks of digit_source_arbiter against a spec-level model.
module tb_digit_source_arbiter;
    localparam int NCH = 2, DW = 5, DWELL = 4;

    logic CLK100MHZ = 1'b0;
    logic CPU_RESET = 1'b1;
    always #5 CLK100MHZ = ~CLK100MHZ;

    digit_source_arbiter_if #(.NCH(NCH), .DIGIT_W(DW)) bus ();
    digit_source_arbiter_if #(.NCH(3),   .DIGIT_W(DW)) bus3 ();

    digit_source_arbiter #(.NCH(NCH), .DIGIT_W(DW), .DWELL(DWELL)) dut (
        .CLK100MHZ(CLK100MHZ), .CPU_RESET(CPU_RESET), .bus(bus.slave));
    digit_source_arbiter #(.NCH(3), .DIGIT_W(DW), .DWELL(DWELL)) dut3 (
        .CLK100MHZ(CLK100MHZ), .CPU_RESET(CPU_RESET), .bus(bus3.slave));

    int errors = 0, checks = 0, upd_cnt = 0;

    // Spec-level model state; m_age counts consecutive auto-rotate edges.
    logic [DW-1:0] m_sh [NCH];
    logic [DW-1:0] m_dh;
    int            m_ac, m_age;
    logic          m_upd;

    task automatic model_edge(input logic [1:0] v, input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                              input logic [1:0] m, input logic s, input logic r);
        logic [DW-1:0] d [NCH];
        logic [DW-1:0] nd;
        int nx;
        d[0] = d0; d[1] = d1;
        if (r) begin
            m_sh[0] = '0; m_sh[1] = '0; m_dh = '0; m_ac = 0; m_upd = 0; m_age = 0;
            return;
        end
        nx = m_ac;
        if (m == 2'b00) nx = int'(s);
        if (m == 2'b01) begin
            if (v[0]) nx = 0;
            else if (v[1]) nx = 1;
        end
        if (m == 2'b10) begin
            if (m_age % DWELL == DWELL - 1) nx = (m_ac + 1) % NCH;
            m_age++;
        end else begin
            m_age = 0;
        end
        if (m != 2'b11) begin
            nd    = v[nx] ? d[nx] : m_sh[nx];
            m_upd = (nd != m_dh) || (nx != m_ac);
            m_dh  = nd;
            m_ac  = nx;
        end else begin
            m_upd = 1'b0;
        end
        for (int i = 0; i < NCH; i++) if (v[i]) m_sh[i] = d[i];
    endtask

    task automatic cyc(input logic [1:0] v, input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                       input logic [1:0] m, input logic s, input logic r);
        bus.ch_valid = v; bus.ch_data = {d1, d0}; bus.mode = m; bus.sel = s; CPU_RESET = r;
        @(posedge CLK100MHZ);
        model_edge(v, d0, d1, m, s, r);
        #1;
        if (bus.updated === 1'b1) upd_cnt++;
        checks += 3;
        if (bus.digit_holder !== m_dh) begin
            errors++; $display("FAIL model_digit: got %0h expected %0h", bus.digit_holder, m_dh);
        end
        if (int'(bus.active_ch) !== m_ac) begin
            errors++; $display("FAIL model_active_ch: got %0d expected %0d", bus.active_ch, m_ac);
        end
        if (bus.updated !== m_upd) begin
            errors++; $display("FAIL model_updated: got %0b expected %0b", bus.updated, m_upd);
        end
    endtask

    task automatic expect_out(input string name, input logic [DW-1:0] dh, input int ac, input logic up);
        // Directed values from the test plan, independent of the model.
        checks++;
        if (bus.digit_holder !== dh || int'(bus.active_ch) !== ac || bus.updated !== up) begin
            errors++;
            $display("FAIL %s: got dh=%0h ac=%0d upd=%0b expected dh=%0h ac=%0d upd=%0b",
                     name, bus.digit_holder, bus.active_ch, bus.updated, dh, ac, up);
        end
    endtask

    task automatic test_reset;
        cyc(2'b00, 0, 0, 2'b00, 0, 1);
        cyc(2'b00, 0, 0, 2'b00, 0, 0);
        expect_out("reset_idle", 5'h00, 0, 1'b0);
        cyc(2'b11, 5'h01, 5'h02, 2'b00, 1, 0);
        expect_out("preload", 5'h02, 1, 1'b1);
        cyc(2'b00, 0, 0, 2'b10, 0, 0);
        cyc(2'b00, 0, 0, 2'b10, 0, 0);
        cyc(2'b11, 5'h1E, 5'h1D, 2'b10, 0, 1);
        expect_out("reset_mid_rotate", 5'h00, 0, 1'b0);
        for (int i = 1; i <= 4; i++) cyc(2'b00, 0, 0, 2'b10, 0, 0);
        expect_out("dwell_restart", 5'h00, 1, 1'b1);
    endtask

    task automatic test_last_event;
        cyc(2'b00, 0, 0, 2'b01, 0, 1);
        cyc(2'b01, 5'h07, 5'h00, 2'b01, 0, 0);
        expect_out("last_ch0", 5'h07, 0, 1'b1);
        cyc(2'b10, 5'h00, 5'h12, 2'b01, 0, 0);
        expect_out("last_ch1", 5'h12, 1, 1'b1);
        cyc(2'b11, 5'h03, 5'h04, 2'b01, 0, 0);
        expect_out("last_tie_low", 5'h03, 0, 1'b1);
    endtask

    task automatic test_manual;
        cyc(2'b11, 5'h0A, 5'h1B, 2'b00, 0, 0);
        cyc(2'b00, 0, 0, 2'b00, 1, 0);
        expect_out("manual_sel1", 5'h1B, 1, 1'b1);
        cyc(2'b00, 0, 0, 2'b00, 0, 0);
        expect_out("manual_sel0", 5'h0A, 0, 1'b1);
    endtask

    task automatic test_rotate;
        int steps;
        steps = 0;
        cyc(2'b00, 0, 0, 2'b00, 0, 1);
        cyc(2'b11, 5'h01, 5'h02, 2'b00, 0, 0);
        for (int i = 1; i <= 8; i++) begin
            cyc(2'b00, 0, 0, 2'b10, 0, 0);
            if (bus.updated === 1'b1) steps++;
            if (i == 3) expect_out("rotate_hold", 5'h01, 0, 1'b0);
            if (i == 4) expect_out("rotate_step1", 5'h02, 1, 1'b1);
            if (i == 8) expect_out("rotate_step2", 5'h01, 0, 1'b1);
        end
        checks++;
        if (steps != 2) begin
            errors++; $display("FAIL rotate_pulses: got %0d expected 2", steps);
        end
    endtask

    task automatic test_freeze;
        cyc(2'b00, 0, 0, 2'b00, 1, 0);
        cyc(2'b10, 5'h00, 5'h1F, 2'b11, 0, 0);
        expect_out("freeze_hold", 5'h02, 1, 1'b0);
        cyc(2'b00, 0, 0, 2'b11, 0, 0);
        cyc(2'b00, 0, 0, 2'b00, 1, 0);
        expect_out("freeze_shadow", 5'h1F, 1, 1'b1);
    endtask

    task automatic test_restrobe;
        cyc(2'b00, 0, 0, 2'b01, 0, 1);
        upd_cnt = 0;
        cyc(2'b01, 5'h07, 0, 2'b01, 0, 0);
        cyc(2'b01, 5'h07, 0, 2'b01, 0, 0);
        cyc(2'b00, 0, 0, 2'b01, 0, 0);
        expect_out("restrobe_value", 5'h07, 0, 1'b0);
        checks++;
        if (upd_cnt != 1) begin
            errors++; $display("FAIL restrobe_pulses: got %0d expected 1", upd_cnt);
        end
    endtask

    task automatic test_random;
        logic [1:0] m;
        m = 2'b00;
        cyc(2'b00, 0, 0, 2'b00, 0, 1);
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 7) == 0) m = 2'($urandom_range(0, 3));
            cyc(2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                m, 1'($urandom_range(0, 1)), $urandom_range(0, 59) == 0);
        end
    endtask

    task automatic test_sel_out_of_range;
        bus3.ch_valid = 3'b111; bus3.ch_data = {5'h03, 5'h02, 5'h01};
        bus3.mode = 2'b00; bus3.sel = 2'd1;
        @(posedge CLK100MHZ); #1;
        bus3.ch_valid = 3'b000; bus3.sel = 2'd3;
        @(posedge CLK100MHZ); #1;
        checks++;
        if (bus3.active_ch !== 2'd1 || bus3.digit_holder !== 5'h02 || bus3.updated !== 1'b0) begin
            errors++;
            $display("FAIL sel_oob: got ac=%0d dh=%0h upd=%0b expected ac=1 dh=2 upd=0",
                     bus3.active_ch, bus3.digit_holder, bus3.updated);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.ch_valid = '0; bus.ch_data = '0; bus.mode = '0; bus.sel = '0;
        bus3.ch_valid = '0; bus3.ch_data = '0; bus3.mode = '0; bus3.sel = '0;
        @(negedge CLK100MHZ);
        test_reset;
        test_last_event;
        test_manual;
        test_rotate;
        test_freeze;
        test_restrobe;
        test_random;
        test_sel_out_of_range;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/digit_source_arbiter.md
Name: digit_source_arbiter

Overview:
- Parametrised successor to the two-way keyboard/ALU digit select feeding disp_7_seg.
- Accepts NCH independent digit-word producers, for example the encoder input digit, the decoder result digit and future sources.
- Holds the latest value from each producer in a shadow register.
- Drives one registered digit_holder word to the 7-segment driver, selected by one of four run-time modes: manual, last-event, auto-rotate, freeze.

Parameters:
- NCH, 2: number of source channels (≥2).
- DIGIT_W, 5: width of each digit word.
- DWELL, 100000000: auto-rotate dwell time in clock cycles (1 s at 100 MHz; ≥2).
- CH_W, $clog2(NCH): localparam, channel index width.

Ports:
- CLK100MHZ  in  1  system clock; all logic on its rising edge.
- CPU_RESET  in  1  synchronous, active-high reset.
- ch_data  in  NCH*DIGIT_W  packed source words; channel i at [i*DIGIT_W +: DIGIT_W].
- ch_valid  in  NCH  per-channel strobe; bit i high = ch_data slice i is new this cycle.
- mode  in  2  00 manual, 01 last-event, 10 auto-rotate, 11 freeze.
- sel  in  CH_W  channel index used in manual mode.
- digit_holder  out  DIGIT_W  registered word to the display driver.
- active_ch  out  CH_W  channel currently driving digit_holder.
- updated  out  1  one-cycle pulse when digit_holder value or active_ch changes.

Behaviour:
- Reset (CPU_RESET high at a clock edge):
  - all shadow registers, digit_holder, active_ch, dwell counter and updated go to 0.
  - Reset overrides every other input in that cycle, including mid-dwell and mid-strobe.
- Shadow capture, all modes including freeze:
  - ch_valid[i] high at edge t → shadow[i] = ch_data slice i from t+1.
- Next-channel selection (nxt), evaluated each cycle:
  - manual: nxt = sel if sel < NCH; otherwise nxt = active_ch (out-of-range sel ignored, no clamp).
  - last-event: if any ch_valid bit is high, nxt = lowest asserted index (lower index wins simultaneous strobes); otherwise nxt = active_ch.
  - auto-rotate: dwell counter increments 0..DWELL-1. At DWELL-1, counter returns to 0 and nxt = active_ch+1, wrapping NCH-1 → 0. Otherwise nxt = active_ch.
  - freeze: nxt = active_ch; digit_holder also holds.
- Dwell counter is held at 0 whenever mode ≠ 10, so entering auto-rotate always gives a full DWELL period before the first step.
- Output register, modes other than freeze:
  - active_ch <= nxt.
  - digit_holder <= ch_data slice nxt if ch_valid[nxt]; otherwise shadow[nxt].
  - The ch_valid bypass gives one-cycle latency from strobe to digit_holder: strobe at edge t → new digit visible after edge t.
- updated <= 1 for one cycle when the new digit_holder differs from the old one, or nxt ≠ active_ch.
  - A re-strobe of an identical value on the active channel produces no pulse.
- Mode changes take effect on the same edge mode is sampled; no pipeline flush required.
- Simultaneous events: a strobe on a non-selected channel updates only its shadow. A strobe on the selected channel in the same cycle as a rotate step is irrelevant unless that channel is the new nxt, in which case the bypass applies.

Test Plan:
Bench uses NCH=2, DIGIT_W=5, DWELL=4.
1. Reset then idle → digit_holder=0, active_ch=0, updated=0. Assert CPU_RESET mid-rotate (counter=2) → all outputs 0 next cycle; counter restarts from 0.
2. Last-event mode:
   - ch_valid=01 with ch0=5'h07 → digit_holder=07, active_ch=0, updated pulse after 1 edge.
   - Then ch_valid=10 with ch1=5'h12 → digit_holder=12, active_ch=1.
   - Then ch_valid=11 with ch0=03, ch1=04 → active_ch=0, digit_holder=03.
3. Manual mode, shadows ch0=0A, ch1=1B:
   - sel=1 → digit_holder=1B next edge.
   - sel=0 → 0A.
   - With NCH=3 build, sel=3 → active_ch unchanged, no updated pulse.
4. Auto-rotate, shadows ch0=01, ch1=02:
   - Switch to mode 10 → active_ch steps 0→1 after 4 cycles, 1→0 after 8.
   - digit_holder alternates 01/02; updated pulses exactly at each step.
5. Freeze with active_ch=1, digit_holder=02, then strobe ch1=1F:
   - digit_holder stays 02.
   - Return to manual, sel=1 → digit_holder=1F (shadow captured during freeze).
6. Identical re-strobe of active channel (ch0=07 twice) in last-event mode → digit_holder=07, only one updated pulse total.
